// File: rtl/data_bus_initiator.sv
// Single-outstanding bus initiator: accepts one command, issues a one-cycle request,
// waits for grant plus read-valid (or a timeout) and holds the response until consumed.
module data_bus_initiator #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic                    cmd_we_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    data_req_o,
  output logic [ADDR_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  output logic                    busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Timer holds the number of WAIT cycles already finished, so the last allowed
  // WAIT cycle is the one that sees TIMEOUT_CYCLES-1.
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        gnt_seen_q;
  logic [15:0] timer_q;
  logic        done;
  logic        timed_out;

  assign done      = data_rvalid_i && (data_gnt_i || gnt_seen_q);
  assign timed_out = (timer_q == LAST_WAIT);

  assign cmd_ready_o = (state_q == IDLE);
  assign data_req_o  = (state_q == ISSUE);
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);

  // NOTE: next state defaults to the current state before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done || timed_out) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
      rsp_rdata_o  <= '0;
      rsp_err_o    <= 1'b0;
      gnt_seen_q   <= 1'b0;
      timer_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          data_addr_o  <= cmd_addr_i;
          data_we_o    <= cmd_we_i;
          data_be_o    <= cmd_be_i;
          data_wdata_o <= cmd_wdata_i;
          gnt_seen_q   <= 1'b0;
          timer_q      <= '0;
        end
        WAIT: begin
          gnt_seen_q <= gnt_seen_q | data_gnt_i;
          timer_q    <= timer_q + 16'd1;
          // Completion wins over a timeout landing in the same cycle.
          if (done) begin
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= data_we_o ? '0 : data_rdata_i;
          end else if (timed_out) begin
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/data_bus_initiator.md
DATA_BUS_INITIATOR -- requirements
Module: data_bus_initiator

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data width of the command, response and bus data.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 2..65535, SHALL set the WAIT cycles allowed before an error response.
REQ-004 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid_i  in  1  command offered.
REQ-007 cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
REQ-008 cmd_addr_i  in  ADDR_WIDTH  target address.
REQ-009 cmd_we_i  in  1  1=write, 0=read.
REQ-010 cmd_be_i  in  DATA_WIDTH/8  byte enables.
REQ-011 cmd_wdata_i  in  DATA_WIDTH  write data.
REQ-012 rsp_valid_o  out  1  response available.
REQ-013 rsp_ready_i  in  1  response consumed when high together with rsp_valid_o.
REQ-014 rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors.
REQ-015 rsp_err_o  out  1  transaction timed out.
REQ-016 data_req_o  out  1  one-cycle request strobe to the responder.
REQ-017 data_addr_o, data_we_o, data_be_o, data_wdata_o  out  ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  transaction fields.
REQ-018 data_gnt_i  in  1  responder grant.
REQ-019 data_rvalid_i  in  1  responder data valid.
REQ-020 data_rdata_i  in  DATA_WIDTH  responder read data.
REQ-021 busy_o  out  1  high in any state other than IDLE.

Function
REQ-022 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; cmd_ready_o SHALL be 1 only in IDLE.
REQ-023 IDLE: on cmd_valid_i&cmd_ready_o, the block SHALL register the addr/we/be/wdata onto data_* and enter ISSUE next cycle.
REQ-024 ISSUE SHALL last exactly one cycle with data_req_o=1, then go to WAIT; data_req_o SHALL be 0 in all other states.
REQ-025 data_addr_o, data_we_o, data_be_o and data_wdata_o SHALL stay stable from ISSUE until the return to IDLE.
REQ-026 WAIT: a sticky gnt_seen flag SHALL set on data_gnt_i; the flag SHALL clear on entry to ISSUE.
REQ-027 WAIT SHALL complete on data_rvalid_i&(data_gnt_i|gnt_seen), going to RESP next cycle with rsp_err_o=0.
REQ-028 On a read completion, rsp_rdata_o SHALL capture data_rdata_i from the completing cycle; on a write completion it SHALL be 0.
REQ-029 data_rvalid_i without a current or prior grant in WAIT SHALL be ignored.
REQ-030 data_gnt_i and data_rvalid_i in IDLE, ISSUE or RESP SHALL be ignored and SHALL NOT change any state.
REQ-031 The timeout counter SHALL clear on entry to ISSUE and increment once per WAIT cycle.
REQ-032 If WAIT has not completed by the end of its TIMEOUT_CYCLES-th cycle, the block SHALL enter RESP with rsp_err_o=1 and rsp_rdata_o=0.
REQ-033 Normal completion SHALL take priority over timeout in the same cycle.
REQ-034 RESP: rsp_valid_o=1, with rsp_rdata_o/rsp_err_o stable, until rsp_ready_i; then the block SHALL return to IDLE next cycle.
REQ-035 A new command SHALL NOT be accepted in the same cycle a response is consumed (one outstanding transaction).
REQ-036 Minimum latency: accept at cycle 0, req at cycle 1, gnt+rvalid at cycle 2, rsp_valid_o at cycle 3.

Reset
REQ-037 During reset the FSM SHALL return to IDLE in the next cycle, including mid-transaction, and the in-flight transaction SHALL be dropped without a response.
REQ-038 Reset values SHALL be: data_req_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, data_addr_o=0, data_we_o=0, data_be_o=0, data_wdata_o=0, gnt_seen=0, counter=0, busy_o=0; cmd_ready_o=1 after reset is released.

Verification
REQ-039 Write addr=0x000, wdata=0x41, be=0xF; responder answers gnt+rvalid 1 cycle after req -> one req pulse at cycle 1; rsp_valid_o at cycle 3; rsp_err_o=0; rsp_rdata_o=0.
REQ-040 Read addr=0x004; gnt at cycle 2, rvalid at cycle 5 with rdata=0x00123456 -> rsp_rdata_o=0x00123456; rsp_err_o=0; rvalid-only pulse at cycle 4 without grant... (replaced by REQ-041).
REQ-041 Read; rvalid pulse before any grant, then gnt+rvalid with rdata=0xDEADBEEF -> the early pulse is ignored; rsp_rdata_o=0xDEADBEEF.
REQ-042 TIMEOUT_CYCLES=4 with a silent responder -> rsp_err_o=1 and rsp_rdata_o=0 after 4 WAIT cycles; data_req_o pulses exactly once.
REQ-043 rsp_ready_i held low for 10 cycles with cmd_valid_i high -> response stable; cmd_ready_o=0 throughout; next command accepted only after IDLE.
REQ-044 Reset asserted in WAIT -> IDLE next cycle; no rsp_valid_o; a late gnt/rvalid arriving in IDLE is ignored.
